// File: rtl/jt89_wr_sched.sv
// rtl/jt89_wr_sched.sv - two-requester write scheduler for the jt89 PSG byte port

// Byte FIFO for one requester; occupancy is registered so full/empty never depend on same-cycle pops
module jt89_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage array needs no reset; only entries behind the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

// Arbitrates two byte streams onto the PSG din port with tone-pair atomicity and write spacing
module jt89_wr_sched #(
    parameter int DEPTH = 4,
    parameter int GAP   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [7:0] a_din,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_din,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] dout,
    output logic       wr_n,
    output logic       busy
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t        state;
    state_t        state_nx;
    logic          lock;
    logic          owner_b;
    logic          last_b;
    logic [GW-1:0] gap_cnt;

    logic          a_full, a_empty, b_full, b_empty;
    logic [7:0]    a_head, b_head;
    logic          grant_a, grant_b;
    logic [7:0]    issue_byte;
    logic          issue_locks;

    assign a_ready = !a_full;
    assign b_ready = !b_full;
    assign busy    = (state != IDLE) || !a_empty || !b_empty;

    jt89_wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .din   (a_din),
        .push  (a_valid && a_ready),
        .pop   (grant_a),
        .head  (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    jt89_wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .din   (b_din),
        .push  (b_valid && b_ready),
        .pop   (grant_b),
        .head  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    // tone latches (bit7=1, bit4=0, channel 0..2) must be followed by their data byte from the same owner
    assign issue_byte  = grant_b ? b_head : a_head;
    assign issue_locks = issue_byte[7] && !issue_byte[4] && (issue_byte[6:5] != 2'b11);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and grant decision: lock owner only, else round-robin on ties
    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        case (state)
            IDLE: begin
                if (lock) begin
                    grant_a = !owner_b && !a_empty;
                    grant_b =  owner_b && !b_empty;
                end else if (!a_empty && !b_empty) begin
                    grant_a =  last_b;
                    grant_b = !last_b;
                end else begin
                    grant_a = !a_empty;
                    grant_b = !b_empty;
                end
                if (grant_a || grant_b) state_nx = ISSUE;
            end
            ISSUE: state_nx = HOLD;
            HOLD: begin
                if (clken && (gap_cnt == GAP_LAST)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // output byte, one-cycle strobe, lock/round-robin memory and gap counting
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= 8'h00;
            wr_n    <= 1'b1;
            lock    <= 1'b0;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            gap_cnt <= '0;
        end else begin
            wr_n <= 1'b1;
            if (grant_a || grant_b) begin
                dout    <= issue_byte;
                wr_n    <= 1'b0;
                last_b  <= grant_b;
                owner_b <= grant_b;
                lock    <= issue_locks;
            end
            if (state == ISSUE)
                gap_cnt <= '0;
            else if ((state == HOLD) && clken)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_jt89_wr_sched.sv
// tb/tb_jt89_wr_sched.sv - self-checking bench for jt89_wr_sched
module tb_jt89_wr_sched;
    localparam int DEPTH = 4;
    localparam int GAP   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clken = 1'b0;
    logic [7:0] a_din = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] b_din = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [7:0] dout;
    logic       wr_n;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } wr_t;
    wr_t wlog[$];

    jt89_wr_sched #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .clken   (clken),
        .a_din   (a_din),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_din   (b_din),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .dout    (dout),
        .wr_n    (wr_n),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor: record every strobed byte with the edge index that asserted it
    always @(negedge clk) begin
        if (wr_n === 1'b0) wlog.push_back('{cyc: cyc, b: dout});
    end

    // reference model: queues per requester, a pulse budget before the next write, lock and last-grant flags
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_lock, m_owner_b, m_last_b, m_skip;
    int         m_need;
    logic [7:0] m_dout;
    bit         m_wr_n;

    always @(posedge clk) begin
        bit ga, gb;
        logic [7:0] issued;
        if (rst) begin
            qa.delete();
            qb.delete();
            m_lock = 0; m_owner_b = 0; m_last_b = 1; m_skip = 0; m_need = 0;
            m_dout = 8'h00; m_wr_n = 1;
        end else begin
            ga = 0; gb = 0; m_wr_n = 1;
            if (m_need == 0 && !m_skip) begin
                if (m_lock) begin
                    ga = !m_owner_b && qa.size() > 0;
                    gb =  m_owner_b && qb.size() > 0;
                end else if (qa.size() > 0 && qb.size() > 0) begin
                    ga = m_last_b;
                    gb = !m_last_b;
                end else begin
                    ga = qa.size() > 0;
                    gb = qb.size() > 0;
                end
            end
            if (a_valid && qa.size() < DEPTH) qa.push_back(a_din);
            if (b_valid && qb.size() < DEPTH) qb.push_back(b_din);
            if (ga || gb) begin
                issued    = ga ? qa.pop_front() : qb.pop_front();
                m_dout    = issued;
                m_wr_n    = 0;
                m_last_b  = gb;
                m_owner_b = gb;
                m_lock    = issued[7] && !issued[4] && (issued[6:5] != 2'b11);
                m_need    = GAP;
                m_skip    = 1;
            end else if (m_skip) begin
                m_skip = 0;
            end else if (m_need > 0 && clken) begin
                m_need = m_need - 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; clken = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wlog.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total += 5;
        if (wr_n !== 1'b1)    begin bad++; $display("FAIL reset_wr_n got=%b exp=1", wr_n); end
        if (dout !== 8'h00)   begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
        if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        clken = 1'b1;
        tick();
        wlog.delete();
        t0 = cyc;
        a_valid = 1'b1; a_din = 8'h9F;
        tick();
        a_din = 8'hBF;
        tick();
        total += 2;
        if (wr_n !== 1'b0)  begin bad++; $display("FAIL single_strobe got=%b exp=0", wr_n); end
        if (dout !== 8'h9F) begin bad++; $display("FAIL single_dout got=%h exp=9f", dout); end
        a_valid = 1'b0;
        tick();
        total += 2;
        if (wr_n !== 1'b1)  begin bad++; $display("FAIL single_strobe_end got=%b exp=1", wr_n); end
        if (dout !== 8'h9F) begin bad++; $display("FAIL single_dout_hold got=%h exp=9f", dout); end
        wait_writes(2, 100);
        repeat (5) tick();
        total++;
        if (wlog.size() != 2) begin
            bad++; $display("FAIL single_count got=%0d exp=2", wlog.size());
        end else begin
            total += 3;
            if (wlog[0].cyc != t0 + 2)  begin bad++; $display("FAIL single_first_edge got=%0d exp=%0d", wlog[0].cyc, t0 + 2); end
            if (wlog[1].cyc != t0 + 36) begin bad++; $display("FAIL single_spacing got=%0d exp=%0d", wlog[1].cyc, t0 + 36); end
            if (wlog[1].b !== 8'hBF)    begin bad++; $display("FAIL single_second_byte got=%h exp=bf", wlog[1].b); end
        end
    endtask

    task automatic check_order(input string name, input logic [7:0] exp[$], input bit check_gap);
        total++;
        if (wlog.size() != exp.size()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", name, wlog.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (wlog[i].b !== exp[i]) begin
                    bad++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, wlog[i].b, exp[i]);
                end
                if (check_gap && i > 0) begin
                    total++;
                    if (wlog[i].cyc - wlog[i-1].cyc != GAP + 2) begin
                        bad++; $display("FAIL %s_gap%0d got=%0d exp=%0d", name, i, wlog[i].cyc - wlog[i-1].cyc, GAP + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp[$];
        do_reset();
        clken = 1'b1;
        wlog.delete();
        a_valid = 1'b1; a_din = 8'h90; b_valid = 1'b1; b_din = 8'hD0;
        tick();
        a_din = 8'hB0; b_din = 8'hF0;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        wait_writes(4, 300);
        repeat (40) tick();
        exp = '{8'h90, 8'hD0, 8'hB0, 8'hF0};
        check_order("rr", exp, 1'b1);
    endtask

    task automatic test_lock();
        logic [7:0] exp[$];
        do_reset();
        clken = 1'b1;
        wlog.delete();
        a_valid = 1'b1; a_din = 8'h81;
        tick();
        a_valid = 1'b0; b_valid = 1'b1; b_din = 8'h9F;
        tick();
        b_valid = 1'b0;
        repeat (100) tick();
        total += 2;
        if (wlog.size() != 1) begin bad++; $display("FAIL lock_stall_count got=%0d exp=1", wlog.size()); end
        if (busy !== 1'b1)    begin bad++; $display("FAIL lock_stall_busy got=%b exp=1", busy); end
        a_valid = 1'b1; a_din = 8'h0C;
        tick();
        a_valid = 1'b0;
        wait_writes(3, 200);
        repeat (5) tick();
        exp = '{8'h81, 8'h0C, 8'h9F};
        check_order("lock", exp, 1'b0);
    endtask

    task automatic test_noise();
        logic [7:0] exp[$];
        do_reset();
        clken = 1'b1;
        wlog.delete();
        a_valid = 1'b1; a_din = 8'hE4; b_valid = 1'b1; b_din = 8'hBF;
        tick();
        a_din = 8'hE5; b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        wait_writes(3, 300);
        repeat (5) tick();
        exp = '{8'hE4, 8'hBF, 8'hE5};
        check_order("noise", exp, 1'b1);
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        clken = 1'b0;
        wlog.delete();
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_din = 8'h90 + 8'(i);
            tick();
        end
        total += 4;
        if (a_ready !== 1'b0)  begin bad++; $display("FAIL bp_a_ready got=%b exp=0", a_ready); end
        if (b_ready !== 1'b1)  begin bad++; $display("FAIL bp_b_ready got=%b exp=1", b_ready); end
        if (busy !== 1'b1)     begin bad++; $display("FAIL bp_busy got=%b exp=1", busy); end
        if (wlog.size() != 1)  begin bad++; $display("FAIL bp_writes got=%0d exp=1", wlog.size()); end
        a_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total += 3;
        if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (wr_n !== 1'b1)    begin bad++; $display("FAIL rst_wr_n got=%b exp=1", wr_n); end
        if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_a_ready got=%b exp=1", a_ready); end
        rst = 1'b0; clken = 1'b1;
        wlog.delete();
        repeat (100) tick();
        total++;
        if (wlog.size() != 0) begin bad++; $display("FAIL rst_no_writes got=%0d exp=0", wlog.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick();
            total += 5;
            if (wr_n !== m_wr_n)     begin bad++; $display("FAIL rnd_wr_n cyc=%0d got=%b exp=%b", cyc, wr_n, m_wr_n); end
            if (dout !== m_dout)     begin bad++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cyc, dout, m_dout); end
            if (a_ready !== (qa.size() < DEPTH)) begin bad++; $display("FAIL rnd_a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, qa.size() < DEPTH); end
            if (b_ready !== (qb.size() < DEPTH)) begin bad++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, qb.size() < DEPTH); end
            if (busy !== (m_need > 0 || m_skip || qa.size() > 0 || qb.size() > 0)) begin
                bad++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, busy);
            end
            rst     = ($urandom_range(0, 799) == 0);
            clken   = ($urandom_range(0, 2) != 0);
            a_valid = ($urandom_range(0, 5) == 0);
            b_valid = ($urandom_range(0, 5) == 0);
            a_din   = 8'($urandom);
            b_din   = 8'($urandom);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_noise();
        test_backpressure_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
